// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
// Watchdog behaviour is selected by the RST_SEQ_TIMEOUT_EN macro in rst_seq_ctl.
package rst_seq_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StHold,
    StStage,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefNumCh      = 4;
  localparam int unsigned DefHoldCyc    = 2;
  localparam int unsigned DefGapCyc     = 1;
  localparam int unsigned DefTimeoutCyc = 20;
  localparam int unsigned DefCntW       = 16;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module rst_seq_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  // Load wins over counting; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctl.sv
// Staged reset sequencer: holds all channels, releases them one by one in
// ascending order, then counts run cycles. Define RST_SEQ_TIMEOUT_EN to enable
// the run-phase watchdog (RUN -> DONE after TIMEOUT_CYC cycles).
module rst_seq_ctl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = DefNumCh,
  parameter int unsigned HOLD_CYC    = DefHoldCyc,
  parameter int unsigned GAP_CYC     = DefGapCyc,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              all_released,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              timeout
);

  localparam int unsigned TmrMax = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int unsigned TmrW   = clog2_min1(TmrMax);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmr_load;
  logic [TmrW-1:0]   tmr_val;
  logic              tmr_expired;

  rst_seq_timer #(
    .W(TmrW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .expired (tmr_expired)
  );

  // State, channel resets and run counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_rst_q <= '1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_rst_q <= ch_rst_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; abort overrides everything below rst.
  always_comb begin
    state_d  = state_q;
    ch_rst_d = ch_rst_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (abort) begin
      state_d  = StIdle;
      ch_rst_d = '1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d  = StHold;
            ch_rst_d = '1;
            tmr_load = 1'b1;
            tmr_val  = TmrW'(HOLD_CYC - 1);
          end
        end
        StHold, StStage: begin
          if (tmr_expired) begin
            // Shifting in zeros releases the next-lowest held channel.
            ch_rst_d = ch_rst_q << 1;
            tmr_load = 1'b1;
            tmr_val  = TmrW'(GAP_CYC - 1);
            if (ch_rst_d == '0) begin
              state_d = StRun;
              cnt_d   = '0;
            end else begin
              state_d = StStage;
            end
          end
        end
        StRun: begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`ifdef RST_SEQ_TIMEOUT_EN
          if (64'(cnt_q) == 64'(TIMEOUT_CYC) - 64'd1) begin
            state_d  = StDone;
            ch_rst_d = '1;
            cnt_d    = cnt_q;
          end
`endif
        end
        default: begin
          state_d  = StIdle;
          ch_rst_d = '1;
        end
      endcase
    end
  end

  assign ch_rst       = ch_rst_q;
  assign all_released = (state_q == StRun);
  assign busy         = (state_q == StHold) || (state_q == StStage);
  assign cycle_cnt    = cnt_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign timeout      = (state_q == StDone);
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: doc/rst_seq_ctl.md
RST_SEQ_CTL -- requirements
Module: rst_seq_ctl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of staged reset channels (1..16).
REQ-002 SHALL have parameter HOLD_CYC, default 2, cycles all channels are held after start (>=1).
REQ-003 SHALL have parameter GAP_CYC, default 1, cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 20, run-phase cycle limit (>=1).
REQ-005 SHALL have parameter CNT_W, default 16, width of the run cycle counter.
REQ-006 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port start  input  1  begin reset sequence; sampled in IDLE or DONE.
REQ-009 SHALL have port abort  input  1  force all channels back into reset.
REQ-010 SHALL have port ch_rst  output  NUM_CH  per-channel reset, 1 = held in reset.
REQ-011 SHALL have port all_released  output  1  high while in RUN.
REQ-012 SHALL have port busy  output  1  high in HOLD or STAGE.
REQ-013 SHALL have port cycle_cnt  output  CNT_W  cycles spent in RUN.
REQ-014 SHALL have port timeout  output  1  high while in DONE after the limit was reached.

Function
REQ-015 SHALL implement the states IDLE, HOLD, STAGE, RUN and DONE.
REQ-016 IDLE: start=1 -> HOLD next cycle; ch_rst all ones.
REQ-017 HOLD: stay exactly HOLD_CYC cycles, then -> STAGE, releasing ch_rst[0] on the transition edge.
REQ-018 STAGE: release ch_rst[i] every GAP_CYC cycles in ascending index; ch_rst bits are monotonic (never re-asserted) during a sequence.
REQ-019 STAGE: the cycle that releases ch_rst[NUM_CH-1] SHALL also enter RUN; with NUM_CH=1, HOLD -> RUN directly.
REQ-020 RUN: cycle_cnt clears to 0 on entry and increments by 1 per cycle; it saturates at 2^CNT_W-1, never wraps.
REQ-021 RUN: when cycle_cnt = TIMEOUT_CYC-1 -> DONE next cycle, ch_rst all ones, timeout=1, cycle_cnt holds.
REQ-022 DONE: start=1 -> HOLD and clears timeout; otherwise hold.
REQ-023 start in HOLD, STAGE or RUN SHALL be ignored.
REQ-024 abort=1 in any state SHALL set ch_rst all ones and state IDLE next cycle, and clear timeout; abort has priority over start and over the timeout transition in the same cycle.
REQ-025 HOLD/GAP timers SHALL reload on every state entry; no residual count carries across an abort.

Reset
REQ-026 rst=1 SHALL, at the next clk edge, force IDLE, ch_rst all ones, all_released=0, busy=0, cycle_cnt=0 and timeout=0, overriding start and abort.
REQ-027 rst asserted mid-sequence SHALL behave identically to REQ-026; no partial release persists.

Configuration
REQ-028 Macro RST_SEQ_TIMEOUT_EN SHALL gate the watchdog: defined -> REQ-021 and REQ-022 apply.
REQ-029 Without RST_SEQ_TIMEOUT_EN: RUN persists until abort or rst; timeout is tied 0; DONE is unreachable; cycle_cnt saturates per REQ-020.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the state enum, the state width and the parameter defaults.
REQ-031 A single sub-module rst_seq_timer (loadable down-counter with an expire flag) SHALL serve both the HOLD and GAP timing.

Verification
REQ-032 rst=1 for 2 cycles, then start pulse (NUM_CH=4, HOLD=2, GAP=1) -> ch_rst 1111 for 2 cycles, then 1110, 1100, 1000, 0000 on consecutive cycles; all_released=1 with 0000.
REQ-033 RUN with TIMEOUT_CYC=20 -> cycle_cnt counts 0..19, then DONE with ch_rst=1111 and timeout=1 on cycle 21.
REQ-034 abort while ch_rst=1100 -> next cycle ch_rst=1111, IDLE, busy=0; a later start replays the full sequence from 1111.
REQ-035 start and abort both high in IDLE -> stays IDLE; start pulse during STAGE -> sequence unchanged.
REQ-036 Build without RST_SEQ_TIMEOUT_EN, CNT_W=4, 30 RUN cycles -> cycle_cnt saturates at 15, timeout=0, ch_rst=0000.
REQ-037 rst pulsed during RUN -> next cycle all outputs at their reset values per REQ-026.
